semafor_directie: RTL and testbench

- Per-direction light-phase sequencer; one instance each for nord, sud, est and vest.
- Sits directly downstream of the intersection control FSM. It consumes that FSM's enable_<dir>/clear_<dir> and returns done_<dir>.
- On enable it runs GREEN -> YELLOW -> ALL_RED with durations counted in prescaled ticks, then raises done until cleared.
- Drives the direction's lamp outputs and a remaining-time value for display.

---
 rtl/semafor_directie_pkg.sv | 29 ++
 rtl/semafor_directie_divizor_tick.sv | 43 ++++
 rtl/semafor_directie.sv | 167 ++++++++++++++++
 tb/tb_semafor_directie.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/semafor_directie_pkg.sv
`default_nettype none
// ============================================================================
// Module   : semafor_pkg
// Brief    : Shared state encoding and lamp vectors for the direction sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package semafor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_ALL_RED = 3'd3,
        ST_DONE    = 3'd4,
        ST_PED     = 3'd5
    } state_t;

    // Lamp vector order is {red, yellow, green}
    localparam logic [2:0] c_lamp_red    = 3'b100;
    localparam logic [2:0] c_lamp_yellow = 3'b010;
    localparam logic [2:0] c_lamp_green  = 3'b001;

    function automatic logic is_active(input state_t s);
        return (s == ST_GREEN) || (s == ST_YELLOW) ||
               (s == ST_ALL_RED) || (s == ST_PED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/semafor_directie_divizor_tick.sv
`default_nettype none
// ============================================================================
// Module   : divizor_tick
// Brief    : Clock prescaler; one-cycle tick every FACTOR_DIVIZARE run cycles.
// Revision : 1.0 - initial release
// ============================================================================
module divizor_tick #(
    parameter int FACTOR_DIVIZARE = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    generate
        if (FACTOR_DIVIZARE == 1) begin : g_div_one
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, clear};
            assign tick     = run;
        end else begin : g_div_cnt
            localparam int c_w = $clog2(FACTOR_DIVIZARE);
            localparam logic [c_w-1:0] c_last = c_w'(FACTOR_DIVIZARE - 1);

            logic [c_w-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (clear) begin
                    r_cnt <= '0;
                end else if (run) begin
                    r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
                end
            end

            assign tick = run && (r_cnt == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/semafor_directie.sv
`default_nettype none
// ============================================================================
// Module   : semafor_directie
// Brief    : Per-direction GREEN->YELLOW->ALL_RED sequencer with done handshake.
//            Optional pedestrian phase when SEMAFOR_PIETON_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module semafor_directie
    import semafor_pkg::*;
#(
    parameter int FACTOR_DIVIZARE = 10,
    parameter int T_GREEN         = 5,
    parameter int T_YELLOW        = 2,
    parameter int T_ALL_RED       = 1,
`ifdef SEMAFOR_PIETON_EN
    parameter int T_PED           = 4,
`endif
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
`ifdef SEMAFOR_PIETON_EN
    input  logic             ped_request,
    output logic             ped_walk,
`endif
    output logic             light_red,
    output logic             light_yellow,
    output logic             light_green,
    output logic             done,
    output logic [CNT_W-1:0] time_left
);

    localparam logic [CNT_W-1:0] c_ld_green   = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] c_ld_yellow  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] c_ld_all_red = CNT_W'(T_ALL_RED - 1);
`ifdef SEMAFOR_PIETON_EN
    localparam logic [CNT_W-1:0] c_ld_ped     = CNT_W'(T_PED - 1);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_active;
    logic             w_tick;
    logic             w_phase_end;
    logic [2:0]       w_lamps;
    logic             r_ped;

    assign w_active    = is_active(r_state);
    assign w_phase_end = w_tick && (r_cnt == '0);

    // Prescaler held at zero outside active phases so every sequence starts aligned
    divizor_tick #(
        .FACTOR_DIVIZARE (FACTOR_DIVIZARE)
    ) u_divizor_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!w_active),
        .run   (w_active),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_tick ? r_cnt - 1'b1 : r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (enable) begin
                    w_state_nxt = ST_GREEN;
                    w_cnt_nxt   = c_ld_green;
                end
            end
            ST_GREEN: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_phase_end) begin
                    w_state_nxt = ST_YELLOW;
                    w_cnt_nxt   = c_ld_yellow;
                end
            end
            ST_YELLOW: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_phase_end) begin
                    w_state_nxt = ST_ALL_RED;
                    w_cnt_nxt   = c_ld_all_red;
                end
            end
            ST_ALL_RED: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
`ifdef SEMAFOR_PIETON_EN
                    if (r_ped) begin
                        w_state_nxt = ST_PED;
                        w_cnt_nxt   = c_ld_ped;
                    end
`endif
                end
            end
`ifdef SEMAFOR_PIETON_EN
            ST_PED: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end
            end
`endif
            ST_DONE: begin
                w_cnt_nxt = '0;
                if (clear) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef SEMAFOR_PIETON_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ped <= 1'b0;
        end else if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
            r_ped <= 1'b0;
        end else if (ped_request) begin
            r_ped <= 1'b1;
        end
    end

    assign ped_walk = (r_state == ST_PED);
`else
    assign r_ped = 1'b0;
`endif

    always_comb begin
        case (r_state)
            ST_GREEN:  w_lamps = c_lamp_green;
            ST_YELLOW: w_lamps = c_lamp_yellow;
            default:   w_lamps = c_lamp_red;
        endcase
    end

    assign {light_red, light_yellow, light_green} = w_lamps;
    assign done      = (r_state == ST_DONE);
    assign time_left = w_active ? r_cnt + CNT_W'(1) : '0;

endmodule
`default_nettype wire

// File: tb/tb_semafor_directie.sv
`default_nettype none
// ============================================================================
// Module   : tb_semafor_directie
// Brief    : Self-checking bench for semafor_directie (elapsed-time model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_semafor_directie;

    localparam int F   = 4;
    localparam int TG  = 3;
    localparam int TY  = 2;
    localparam int TAR = 1;
    localparam int TPD = 4;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          clear_drv;
    logic          tie_clear;
    logic          clear;
    logic          light_red, light_yellow, light_green, done;
    logic [CW-1:0] time_left;
    logic          walk_act;
`ifdef SEMAFOR_PIETON_EN
    logic          ped_request;
    logic          ped_walk;
    assign walk_act = ped_walk;
`else
    assign walk_act = 1'b0;
`endif

    assign clear = tie_clear ? done : clear_drv;

    always #5 clk = ~clk;

    semafor_directie #(
        .FACTOR_DIVIZARE (F),
        .T_GREEN         (TG),
        .T_YELLOW        (TY),
        .T_ALL_RED       (TAR),
`ifdef SEMAFOR_PIETON_EN
        .T_PED           (TPD),
`endif
        .CNT_W           (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clear        (clear),
`ifdef SEMAFOR_PIETON_EN
        .ped_request  (ped_request),
        .ped_walk     (ped_walk),
`endif
        .light_red    (light_red),
        .light_yellow (light_yellow),
        .light_green  (light_green),
        .done         (done),
        .time_left    (time_left)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase number (0 idle,1 green,2 yellow,3 all-red,4 done,5 ped)
    // plus cycles elapsed in the phase; each phase lasts duration*F cycles.
    int m_ph = 0;
    int m_e  = 0;
    bit m_ped = 1'b0;

    function automatic int dur(input int ph);
        case (ph)
            1:       return TG;
            2:       return TY;
            3:       return TAR;
            5:       return TPD;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int nph;
        bit clr_eff;
        if (!rst_n) begin
            m_ph  = 0;
            m_e   = 0;
            m_ped = 1'b0;
        end else begin
            nph     = m_ph;
            clr_eff = tie_clear ? (m_ph == 4) : clear_drv;
            case (m_ph)
                0: if (enable) begin nph = 1; m_e = 0; end
                1, 2: begin
                    if (!enable) begin
                        nph = 0; m_e = 0;
                    end else begin
                        m_e++;
                        if (m_e == dur(m_ph) * F) begin nph = m_ph + 1; m_e = 0; end
                    end
                end
                3: begin
                    m_e++;
                    if (m_e == TAR * F) begin nph = m_ped ? 5 : 4; m_e = 0; end
                end
                5: begin
                    m_e++;
                    if (m_e == TPD * F) begin nph = 4; m_e = 0; end
                end
                4: if (clr_eff) nph = 0;
                default: nph = 0;
            endcase
`ifdef SEMAFOR_PIETON_EN
            if (nph == 4 && m_ph != 4) m_ped = 1'b0;
            else if (ped_request)      m_ped = 1'b1;
`endif
            m_ph = nph;
        end
    end

    function automatic logic [12:0] exp_vec();
        logic [7:0] tl;
        tl = (m_ph inside {1, 2, 3, 5}) ? 8'(dur(m_ph) - m_e / F) : 8'd0;
        return {m_ph inside {0, 3, 4, 5}, m_ph == 2, m_ph == 1, m_ph == 4, m_ph == 5, tl};
    endfunction

    always @(negedge clk) begin
        chk("cycle_outputs",
            {19'd0, light_red, light_yellow, light_green, done, walk_act, time_left},
            {19'd0, exp_vec()});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear_drv = 1'b0; tie_clear = 1'b1;
`ifdef SEMAFOR_PIETON_EN
        ped_request = 1'b0;
`endif
        step(2);
        chk("reset_red", light_red, 1);
        chk("reset_green", light_green, 0);
        chk("reset_done", done, 0);
        chk("reset_time", time_left, 0);
        rst_n = 1'b1;
        step(1);

        // Nominal run, enable held high through DONE (back-to-back restart)
        enable = 1'b1;
        step(1);  chk("nom_c1_green", light_green, 1); chk("nom_c1_tl", time_left, 3);
        step(11); chk("nom_c12_green", light_green, 1); chk("nom_c12_tl", time_left, 1);
        step(1);  chk("nom_c13_yellow", light_yellow, 1); chk("nom_c13_tl", time_left, 2);
        step(7);  chk("nom_c20_yellow", light_yellow, 1);
        step(1);  chk("nom_c21_red", light_red, 1); chk("nom_c21_tl", time_left, 1);
        step(4);  chk("nom_c25_done", done, 1); chk("nom_c25_tl", time_left, 0);
        step(1);  chk("b2b_idle_done", done, 0); chk("b2b_idle_green", light_green, 0);
        step(1);  chk("b2b_green", light_green, 1); chk("b2b_tl", time_left, 3);

        // Abort in GREEN, re-enable, late clear, clear pulse in GREEN ignored
        step(5);  enable = 1'b0;
        step(1);  chk("abort_red", light_red, 1); chk("abort_done", done, 0);
        enable = 1'b1; tie_clear = 1'b0; clear_drv = 1'b0;
        step(1);  chk("reen_green", light_green, 1); clear_drv = 1'b1;
        step(1);  chk("clr_in_green", light_green, 1); clear_drv = 1'b0;
        step(10); chk("reen_c19_green", light_green, 1); chk("reen_c19_tl", time_left, 1);
        step(1);  chk("reen_c20_yellow", light_yellow, 1);
        step(8);  chk("reen_c28_red", light_red, 1); enable = 1'b0;
        step(4);  chk("late_done", done, 1);
        step(10); chk("late_done_held", done, 1); chk("late_red_held", light_red, 1);
        clear_drv = 1'b1;
        step(1);  chk("late_cleared", done, 0); clear_drv = 1'b0; tie_clear = 1'b1;
        step(2);  chk("idle_stays", light_green, 0);

        // Asynchronous reset mid-YELLOW
        enable = 1'b1;
        step(14); chk("pre_rst_yellow", light_yellow, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_red", light_red, 1); chk("arst_yellow", light_yellow, 0);
        chk("arst_done", done, 0); chk("arst_tl", time_left, 0);
        enable = 1'b0;
        step(1);  rst_n = 1'b1;
        step(1);

`ifdef SEMAFOR_PIETON_EN
        enable = 1'b1;
        step(5);  ped_request = 1'b1;
        step(1);  ped_request = 1'b0;
        step(19); chk("ped_c25_walk", ped_walk, 1); chk("ped_c25_red", light_red, 1);
                  chk("ped_c25_tl", time_left, 4);
        step(5);  enable = 1'b0;
        step(10); chk("ped_c40_walk", ped_walk, 1); chk("ped_c40_tl", time_left, 1);
        step(1);  chk("ped_c41_done", done, 1); chk("ped_c41_walk", ped_walk, 0);
        step(1);  enable = 1'b1;
        step(25); chk("noped_done", done, 1); chk("noped_walk", ped_walk, 0);
        enable = 1'b0;
        step(1);  chk("noped_idle", done, 0);
`endif

        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
